// File: rtl/alu_cmd_sequencer_if.sv
// Command, ALU-drive and response signals of the ALU command sequencer.
// The sequencer uses the master modport. The command producer, the ALU and the
// response consumer together form the slave side.
interface alu_cmd_sequencer_if #(
  parameter int DATA_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic [DATA_W-1:0] cmd_a;
  logic [DATA_W-1:0] cmd_b;
  logic              cmd_chain;

  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [2:0]        alu_sel;
  logic [DATA_W-1:0] alu_y;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic [2:0]        rsp_op;

  modport master (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_chain, alu_y, rsp_ready,
    output cmd_ready, alu_a, alu_b, alu_sel, rsp_valid, rsp_data, rsp_op
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_chain, alu_y, rsp_ready,
    input  cmd_ready, alu_a, alu_b, alu_sel, rsp_valid, rsp_data, rsp_op
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// ALU command sequencer. It queues ALU commands, drives registered operands to
// an external combinational ALU, captures each result one cycle later, and
// returns the results over a valid/ready response channel.
//
// state | meaning
// IDLE  | no command in flight. ALU registers hold their last values.
// EXEC  | ALU inputs are stable. The result is captured on the next edge.
// RESP  | a result is offered on rsp_*. It is held until rsp_ready.
module alu_cmd_sequencer #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  alu_cmd_sequencer_if.master      bus,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state, state_nxt;

  logic [2:0]        q_op    [DEPTH];
  logic [DATA_W-1:0] q_a     [DEPTH];
  logic [DATA_W-1:0] q_b     [DEPTH];
  logic              q_chain [DEPTH];

  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic              full, empty, push, pop, capture, rsp_hs;
  logic [DATA_W-1:0] last_result, chain_src;

  assign full          = (level == LW'(DEPTH));
  assign empty         = (level == '0);
  assign bus.cmd_ready = !full;
  assign push          = bus.cmd_valid && !full;
  assign busy          = (state != IDLE) || !empty;

  // A back-to-back pop from RESP takes the result being handed off now, because
  // last_result is only updated on that same edge.
  assign chain_src = (state == RESP) ? bus.rsp_data : last_result;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and per-cycle control strobes
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    capture   = 1'b0;
    rsp_hs    = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        capture   = 1'b1;
        state_nxt = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_hs = 1'b1;
          if (!empty) begin
            pop       = 1'b1;
            state_nxt = EXEC;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FIFO storage. It is not reset because reset clears the pointers and level.
  always_ff @(posedge clk) begin
    if (push) begin
      q_op[wr_ptr]    <= bus.cmd_op;
      q_a[wr_ptr]     <= bus.cmd_a;
      q_b[wr_ptr]     <= bus.cmd_b;
      q_chain[wr_ptr] <= bus.cmd_chain;
    end
  end

  // FIFO pointers and occupancy. The pointers wrap naturally at power-of-2 DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Load the ALU operand registers from the FIFO head on every pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.alu_a   <= '0;
      bus.alu_b   <= '0;
      bus.alu_sel <= '0;
    end else if (pop) begin
      bus.alu_a   <= q_chain[rd_ptr] ? chain_src : q_a[rd_ptr];
      bus.alu_b   <= q_b[rd_ptr];
      bus.alu_sel <= q_op[rd_ptr];
    end
  end

  // Capture the ALU result, hold it until handshake, and remember the last accepted result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= '0;
      bus.rsp_op    <= '0;
      last_result   <= '0;
    end else begin
      if (capture) begin
        bus.rsp_valid <= 1'b1;
        bus.rsp_data  <= bus.alu_y;
        bus.rsp_op    <= bus.alu_sel;
      end else if (rsp_hs) begin
        bus.rsp_valid <= 1'b0;
      end
      if (rsp_hs) last_result <= bus.rsp_data;
    end
  end

endmodule
